// File: rtl/axi_ram_tester.sv
// AXI4 RAM self-test initiator: fills a region with an address-derived pattern
// using INCR write bursts, then reads it back and counts every mismatching beat.
module axi_ram_tester #(
    parameter int          ID_WIDTH  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_BEATS = 64,
    parameter int          BURST_LEN = 8,
    parameter int          TXN_ID    = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic [15:0]         o_err_count,

    output logic [ID_WIDTH-1:0] o_awid,
    output logic [31:0]         o_awaddr,
    output logic [7:0]          o_awlen,
    output logic [2:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,

    output logic [63:0]         o_wdata,
    output logic [7:0]          o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,

    input  logic [ID_WIDTH-1:0] i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready,

    output logic [ID_WIDTH-1:0] o_arid,
    output logic [31:0]         o_araddr,
    output logic [7:0]          o_arlen,
    output logic [2:0]          o_arsize,
    output logic [1:0]          o_arburst,
    output logic                o_arvalid,
    input  logic                i_arready,

    input  logic [ID_WIDTH-1:0] i_rid,
    input  logic [63:0]         i_rdata,
    input  logic [1:0]          i_rresp,
    input  logic                i_rlast,
    input  logic                i_rvalid,
    output logic                o_rready
);

    localparam int                NUM_BURSTS  = NUM_BEATS / BURST_LEN;
    localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [31:0]       LAST_BURST  = 32'(NUM_BURSTS - 1);
    localparam logic [31:0]       BURST_BYTES = 32'(BURST_LEN * 8);
    localparam logic [ID_WIDTH-1:0] ID        = ID_WIDTH'(TXN_ID);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WA,
        S_WD,
        S_WB,
        S_RA,
        S_RD,
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] burst_addr;
    logic [31:0] beat_addr;
    logic [31:0] burst_idx;
    logic [7:0]  beat;

    logic [31:0] next_burst_addr;
    logic [31:0] next_beat_addr;
    logic        b_err;
    logic        r_err;

    function automatic logic [63:0] pattern(input logic [31:0] addr);
        return {~addr, addr};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    assign o_awid    = ID;
    assign o_arid    = ID;
    assign o_awlen   = LAST_BEAT;
    assign o_arlen   = LAST_BEAT;
    assign o_awsize  = 3'b011;
    assign o_arsize  = 3'b011;
    assign o_awburst = 2'b01;
    assign o_arburst = 2'b01;
    assign o_wstrb   = 8'hFF;
    assign o_awaddr  = burst_addr;
    assign o_araddr  = burst_addr;

    assign next_burst_addr = burst_addr + BURST_BYTES;
    assign next_beat_addr  = beat_addr + 32'd8;

    // Read beats are checked straight off the bus against the regenerated pattern.
    assign b_err = (i_bresp != 2'b00) || (i_bid != ID);
    assign r_err = (i_rdata != pattern(beat_addr)) || (i_rresp != 2'b00) ||
                   (i_rid != ID) || (i_rlast != (beat == LAST_BEAT));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            burst_addr  <= 32'd0;
            beat_addr   <= 32'd0;
            burst_idx   <= 32'd0;
            beat        <= 8'd0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_err_count <= 16'd0;
            o_awvalid   <= 1'b0;
            o_wvalid    <= 1'b0;
            o_wdata     <= 64'd0;
            o_wlast     <= 1'b0;
            o_bready    <= 1'b0;
            o_arvalid   <= 1'b0;
            o_rready    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_done      <= 1'b0;
                        o_pass      <= 1'b0;
                        o_err_count <= 16'd0;
                        o_busy      <= 1'b1;
                        burst_addr  <= BASE_ADDR;
                        burst_idx   <= 32'd0;
                        o_awvalid   <= 1'b1;
                        state       <= S_WA;
                    end
                end

                S_WA: begin
                    if (i_awready) begin
                        o_awvalid <= 1'b0;
                        beat      <= 8'd0;
                        beat_addr <= burst_addr;
                        o_wvalid  <= 1'b1;
                        o_wdata   <= pattern(burst_addr);
                        o_wlast   <= (LAST_BEAT == 8'd0);
                        state     <= S_WD;
                    end
                end

                // Data and wlast only move on an accepted beat, so they hold while stalled.
                S_WD: begin
                    if (i_wready) begin
                        if (beat == LAST_BEAT) begin
                            o_wvalid <= 1'b0;
                            o_wlast  <= 1'b0;
                            o_bready <= 1'b1;
                            state    <= S_WB;
                        end else begin
                            beat      <= beat + 8'd1;
                            beat_addr <= next_beat_addr;
                            o_wdata   <= pattern(next_beat_addr);
                            o_wlast   <= ((beat + 8'd1) == LAST_BEAT);
                        end
                    end
                end

                S_WB: begin
                    if (i_bvalid) begin
                        o_bready <= 1'b0;
                        if (b_err) begin
                            o_err_count <= sat_inc(o_err_count);
                        end
                        if (burst_idx == LAST_BURST) begin
                            burst_idx  <= 32'd0;
                            burst_addr <= BASE_ADDR;
                            o_arvalid  <= 1'b1;
                            state      <= S_RA;
                        end else begin
                            burst_idx  <= burst_idx + 32'd1;
                            burst_addr <= next_burst_addr;
                            o_awvalid  <= 1'b1;
                            state      <= S_WA;
                        end
                    end
                end

                S_RA: begin
                    if (i_arready) begin
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                        beat      <= 8'd0;
                        beat_addr <= burst_addr;
                        state     <= S_RD;
                    end
                end

                S_RD: begin
                    if (i_rvalid) begin
                        if (r_err) begin
                            o_err_count <= sat_inc(o_err_count);
                        end
                        if (beat == LAST_BEAT) begin
                            o_rready <= 1'b0;
                            if (burst_idx == LAST_BURST) begin
                                state <= S_DONE;
                            end else begin
                                burst_idx  <= burst_idx + 32'd1;
                                burst_addr <= next_burst_addr;
                                o_arvalid  <= 1'b1;
                                state      <= S_RA;
                            end
                        end else begin
                            beat      <= beat + 8'd1;
                            beat_addr <= next_beat_addr;
                        end
                    end
                end

                S_DONE: begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    o_pass <= (o_err_count == 16'd0);
                    state  <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_tester.sv
// Bench for axi_ram_tester: reactive AXI RAM slave, handshake monitor and
// per-scenario tasks comparing scoreboard queues and final status.
module tb_axi_ram_tester;

    localparam int NB = 32;
    localparam int BL = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_start = 1'b0;
    logic        o_busy, o_done, o_pass;
    logic [15:0] o_err_count;
    logic [3:0]  o_awid, o_arid, i_bid, i_rid;
    logic [31:0] o_awaddr, o_araddr;
    logic [7:0]  o_awlen, o_arlen, o_wstrb;
    logic [2:0]  o_awsize, o_arsize;
    logic [1:0]  o_awburst, o_arburst, i_bresp, i_rresp;
    logic        o_awvalid, i_awready, o_wlast, o_wvalid, i_wready;
    logic        i_bvalid, o_bready, o_arvalid, i_arready;
    logic        i_rlast, i_rvalid, o_rready;
    logic [63:0] o_wdata, i_rdata;

    always #5 clk = ~clk;

    axi_ram_tester #(
        .ID_WIDTH(4), .BASE_ADDR(32'h0), .NUM_BEATS(NB), .BURST_LEN(BL), .TXN_ID(0)
    ) dut (
        .clk(clk), .rstn(rstn), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_err_count(o_err_count),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
        .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
        .i_rvalid(i_rvalid), .o_rready(o_rready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Slave knobs, written only by the test tasks.
    bit bp_en       = 1'b0;
    bit corrupt_en  = 1'b0;
    int corrupt_ar  = 0;
    int corrupt_wrd = 9;
    int berr_idx    = -1;
    int rerr_beat   = -1;

    logic [63:0] mem [0:63];
    logic [31:0] w_ptr, r_ptr;
    logic [3:0]  bid_q, rid_q;
    bit          b_pending;
    int          b_delay, r_left, b_idx, ar_idx, r_issued;

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {~a, a};
    endfunction

    // Behavioural AXI RAM: optional random ready/valid delays and error injection.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i_awready <= 1'b0; i_wready <= 1'b0; i_arready <= 1'b0;
            i_bvalid  <= 1'b0; i_bresp  <= 2'b00; i_bid <= 4'd0;
            i_rvalid  <= 1'b0; i_rdata  <= 64'd0; i_rresp <= 2'b00;
            i_rlast   <= 1'b0; i_rid    <= 4'd0;
            w_ptr <= 32'd0; r_ptr <= 32'd0; bid_q <= 4'd0; rid_q <= 4'd0;
            b_pending <= 1'b0; b_delay <= 0; r_left <= 0;
            b_idx <= 0; ar_idx <= 0; r_issued <= 0;
        end else begin
            i_awready <= bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            i_wready  <= bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            i_arready <= bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_awvalid && i_awready) begin
                w_ptr <= o_awaddr;
                bid_q <= o_awid;
            end
            if (o_wvalid && i_wready) begin
                mem[w_ptr[8:3]] <= o_wdata;
                w_ptr <= w_ptr + 32'd8;
                if (o_wlast) begin
                    b_pending <= 1'b1;
                    b_delay   <= bp_en ? int'($urandom_range(0, 3)) : 0;
                end
            end
            if (i_bvalid && o_bready) begin
                i_bvalid <= 1'b0;
                b_idx    <= b_idx + 1;
            end
            if (b_pending) begin
                if (b_delay == 0) begin
                    i_bvalid  <= 1'b1;
                    i_bresp   <= (b_idx == berr_idx) ? 2'b10 : 2'b00;
                    i_bid     <= bid_q;
                    b_pending <= 1'b0;
                end else begin
                    b_delay <= b_delay - 1;
                end
            end
            if (o_arvalid && i_arready) begin
                r_ptr  <= o_araddr;
                r_left <= int'(o_arlen) + 1;
                rid_q  <= o_arid;
                ar_idx <= ar_idx + 1;
                if (corrupt_en && ar_idx == corrupt_ar)
                    mem[corrupt_wrd] <= mem[corrupt_wrd] ^ 64'h1;
            end
            if (i_rvalid && o_rready)
                i_rvalid <= 1'b0;
            if (r_left != 0 && (!i_rvalid || o_rready) &&
                (!bp_en || $urandom_range(0, 2) == 0)) begin
                i_rvalid <= 1'b1;
                i_rdata  <= mem[r_ptr[8:3]];
                i_rlast  <= (r_left == 1);
                i_rresp  <= (r_issued == rerr_beat) ? 2'b10 : 2'b00;
                i_rid    <= rid_q;
                r_ptr    <= r_ptr + 32'd8;
                r_left   <= r_left - 1;
                r_issued <= r_issued + 1;
            end
        end
    end

    // Handshake recorder and stall-stability watcher, sampled mid-cycle.
    logic [31:0] obs_aw [$];
    logic [31:0] obs_ar [$];
    logic [64:0] obs_w  [$];
    int          stall_viol = 0;
    logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
    logic        p_arv = 1'b0, p_arr = 1'b0, p_wl = 1'b0;
    logic [31:0] p_awa = 32'd0, p_ara = 32'd0;
    logic [63:0] p_wd = 64'd0;

    always @(negedge clk) begin
        if (!rstn) begin
            p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
        end else begin
            if ((p_awv && !p_awr && (!o_awvalid || o_awaddr != p_awa)) ||
                (p_wv && !p_wr && (!o_wvalid || o_wdata != p_wd || o_wlast != p_wl)) ||
                (p_arv && !p_arr && (!o_arvalid || o_araddr != p_ara)) ||
                (32'(o_awvalid & i_awready) + 32'(o_wvalid & i_wready) +
                 32'(o_arvalid & i_arready) + 32'(i_bvalid & o_bready) +
                 32'(i_rvalid & o_rready) > 32'd1))
                stall_viol <= stall_viol + 1;
            if (o_awvalid && i_awready) obs_aw.push_back(o_awaddr);
            if (o_arvalid && i_arready) obs_ar.push_back(o_araddr);
            if (o_wvalid && i_wready)   obs_w.push_back({o_wlast, o_wdata});
            p_awv <= o_awvalid; p_awr <= i_awready; p_awa <= o_awaddr;
            p_wv  <= o_wvalid;  p_wr  <= i_wready;  p_wd  <= o_wdata; p_wl <= o_wlast;
            p_arv <= o_arvalid; p_arr <= i_arready; p_ara <= o_araddr;
        end
    end

    logic [31:0] exp_aw [$];
    logic [31:0] exp_ar [$];
    logic [64:0] exp_w  [$];

    task automatic push_expected(input bit with_data);
        for (int i = 0; i < NB / BL; i++) begin
            exp_aw.push_back(32'(i * BL * 8));
            exp_ar.push_back(32'(i * BL * 8));
        end
        if (with_data)
            for (int i = 0; i < NB; i++)
                exp_w.push_back({1'((i % BL) == BL - 1), pat(32'(i * 8))});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (o_done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_valids: got %b want 00000",
                     {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready});
        end
        n_tests++;
        if ({o_busy, o_done, o_pass, o_err_count} !== 19'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_status: busy=%b done=%b pass=%b cnt=%0d want all 0",
                     o_busy, o_done, o_pass, o_err_count);
        end
        n_tests++;
        if ({o_awsize, o_awburst, o_awlen, o_arsize, o_arburst, o_arlen, o_wstrb, o_awid, o_arid}
            !== {3'b011, 2'b01, 8'd7, 3'b011, 2'b01, 8'd7, 8'hFF, 4'd0, 4'd0}) begin
            n_fail++;
            $display("[TB] FAIL const_outputs: awsize=%h awburst=%h awlen=%h arsize=%h arburst=%h arlen=%h wstrb=%h",
                     o_awsize, o_awburst, o_awlen, o_arsize, o_arburst, o_arlen, o_wstrb);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to;
        int aw0 = obs_aw.size(), ar0 = obs_ar.size(), w0 = obs_w.size();
        int idx;
        logic [31:0] e, got;
        logic [64:0] ew, gw;
        push_expected(1'b1);
        pulse_start();
        wait_done(to);
        n_tests++;
        if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_timeout: done never rose"); end
        n_tests++;
        if (obs_aw.size() - aw0 !== 4 || obs_ar.size() - ar0 !== 4) begin
            n_fail++;
            $display("[TB] FAIL basic_hs_count: aw=%0d ar=%0d want 4/4",
                     obs_aw.size() - aw0, obs_ar.size() - ar0);
        end
        idx = aw0;
        while (exp_aw.size() > 0) begin
            e = exp_aw.pop_front();
            got = (idx < obs_aw.size()) ? obs_aw[idx] : 32'hDEAD_BEEF;
            idx++;
            n_tests++;
            if (got !== e) begin n_fail++; $display("[TB] FAIL basic_awaddr: got %h want %h", got, e); end
        end
        idx = ar0;
        while (exp_ar.size() > 0) begin
            e = exp_ar.pop_front();
            got = (idx < obs_ar.size()) ? obs_ar[idx] : 32'hDEAD_BEEF;
            idx++;
            n_tests++;
            if (got !== e) begin n_fail++; $display("[TB] FAIL basic_araddr: got %h want %h", got, e); end
        end
        idx = w0;
        while (exp_w.size() > 0) begin
            ew = exp_w.pop_front();
            gw = (idx < obs_w.size()) ? obs_w[idx] : 65'd0;
            idx++;
            n_tests++;
            if (gw !== ew) begin n_fail++; $display("[TB] FAIL basic_wbeat: got %h want %h", gw, ew); end
        end
        n_tests++;
        if (mem[8] !== 64'hFFFFFFBF_00000040) begin
            n_fail++;
            $display("[TB] FAIL basic_word_0x40: got %h want ffffffbf00000040", mem[8]);
        end
        n_tests++;
        if ({o_done, o_pass, o_busy, o_err_count} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
            n_fail++;
            $display("[TB] FAIL basic_result: done=%b pass=%b busy=%b cnt=%0d want 1 1 0 0",
                     o_done, o_pass, o_busy, o_err_count);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({o_done, o_pass} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL basic_done_hold: done=%b pass=%b want 1 1", o_done, o_pass);
        end
    endtask

    task automatic test_corrupt();
        bit to;
        corrupt_ar  = ar_idx;
        corrupt_wrd = 9;
        corrupt_en  = 1'b1;
        pulse_start();
        wait_done(to);
        corrupt_en = 1'b0;
        n_tests++;
        if ({to, o_pass, o_err_count} !== {1'b0, 1'b0, 16'd1}) begin
            n_fail++;
            $display("[TB] FAIL corrupt_result: timeout=%b pass=%b cnt=%0d want 0 0 1",
                     to, o_pass, o_err_count);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int sv0 = stall_viol, aw0 = obs_aw.size(), w0 = obs_w.size();
        int idx;
        logic [31:0] e, got;
        logic [64:0] ew, gw;
        bp_en = 1'b1;
        push_expected(1'b1);
        pulse_start();
        wait_done(to);
        bp_en = 1'b0;
        n_tests++;
        if (stall_viol - sv0 !== 0) begin
            n_fail++;
            $display("[TB] FAIL bp_stability: violations=%0d want 0", stall_viol - sv0);
        end
        idx = aw0;
        while (exp_aw.size() > 0) begin
            e = exp_aw.pop_front();
            got = (idx < obs_aw.size()) ? obs_aw[idx] : 32'hDEAD_BEEF;
            idx++;
            n_tests++;
            if (got !== e) begin n_fail++; $display("[TB] FAIL bp_awaddr: got %h want %h", got, e); end
        end
        exp_ar.delete();
        idx = w0;
        while (exp_w.size() > 0) begin
            ew = exp_w.pop_front();
            gw = (idx < obs_w.size()) ? obs_w[idx] : 65'd0;
            idx++;
            n_tests++;
            if (gw !== ew) begin n_fail++; $display("[TB] FAIL bp_wbeat: got %h want %h", gw, ew); end
        end
        n_tests++;
        if ({to, o_done, o_pass, o_err_count} !== {1'b0, 1'b1, 1'b1, 16'd0}) begin
            n_fail++;
            $display("[TB] FAIL bp_result: timeout=%b done=%b pass=%b cnt=%0d want 0 1 1 0",
                     to, o_done, o_pass, o_err_count);
        end
    endtask

    task automatic test_error_resp();
        bit to;
        berr_idx  = b_idx + 2;
        rerr_beat = r_issued + 13;
        pulse_start();
        wait_done(to);
        berr_idx  = -1;
        rerr_beat = -1;
        n_tests++;
        if ({to, o_pass, o_err_count} !== {1'b0, 1'b0, 16'd2}) begin
            n_fail++;
            $display("[TB] FAIL resp_errors: timeout=%b pass=%b cnt=%0d want 0 0 2",
                     to, o_pass, o_err_count);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit hit = 1'b0;
        pulse_start();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (o_wvalid && o_wdata == pat(32'd24)) begin
                hit = 1'b1;
                break;
            end
        end
        #1 rstn = 1'b0;
        #1;
        n_tests++;
        if ({hit, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready} !== 6'b100000) begin
            n_fail++;
            $display("[TB] FAIL midreset_valids: hit=%b aw=%b w=%b b=%b ar=%b r=%b want 1 0 0 0 0 0",
                     hit, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready);
        end
        n_tests++;
        if ({o_busy, o_done, o_err_count} !== 18'd0) begin
            n_fail++;
            $display("[TB] FAIL midreset_status: busy=%b done=%b cnt=%0d want 0 0 0",
                     o_busy, o_done, o_err_count);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_done(to);
        n_tests++;
        if ({to, o_pass, o_err_count} !== {1'b0, 1'b1, 16'd0}) begin
            n_fail++;
            $display("[TB] FAIL midreset_rerun: timeout=%b pass=%b cnt=%0d want 0 1 0",
                     to, o_pass, o_err_count);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int aw0 = obs_aw.size(), ar0 = obs_ar.size();
        int idx;
        logic [31:0] e, got;
        push_expected(1'b0);
        pulse_start();
        repeat (20) @(negedge clk);
        pulse_start();
        wait_done(to);
        n_tests++;
        if ({to, o_pass} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL busy_start_result: timeout=%b pass=%b want 0 1", to, o_pass);
        end
        idx = ar0;
        while (exp_ar.size() > 0) begin
            e = exp_ar.pop_front();
            got = (idx < obs_ar.size()) ? obs_ar[idx] : 32'hDEAD_BEEF;
            idx++;
            n_tests++;
            if (got !== e) begin n_fail++; $display("[TB] FAIL busy_start_araddr: got %h want %h", got, e); end
        end
        exp_aw.delete();
        repeat (10) @(negedge clk);
        n_tests++;
        if ({obs_aw.size() - aw0, obs_ar.size() - ar0, o_busy} !== {32'd4, 32'd4, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL busy_start_no_restart: aw=%0d ar=%0d busy=%b want 4 4 0",
                     obs_aw.size() - aw0, obs_ar.size() - ar0, o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corrupt();
        test_backpressure();
        test_error_resp();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
